l_transform_pipe: RTL and testbench
===================================

Name: l_transform_pipe

Overview:
Parametrised successor to the single-word encode/decode L stage.
- Applies either the SM4 round linear transform L (rotations 2/10/18/24) or the key-expansion transform L' (rotations 13/23), selected per beat.
- Processes LANES independent 32-bit words per beat through an elastic valid/ready pipeline of DEPTH register stages.
- Sits between the S-box (tau) stage and the round XOR, and is shared by the encrypt/decrypt datapath and the key-schedule datapath.

Parameters:
- WORD_WIDTH, 32: word width; fixed by the SM4 rotation amounts, and any other value is a configuration error.
- LANES, 1: number of words transformed in parallel per beat (1..4).
- DEPTH, 1: number of pipeline register stages (1..4); stage 0 holds the transform result, later stages are elastic delay.
- TAG_WIDTH, 4: width of the sideband tag carried alongside each beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all stages
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_mode  in  1  0 = L (enc/dec), 1 = L' (key expansion)
- in_tag  in  TAG_WIDTH  sideband, passed through unchanged
- in_data  in  LANES*WORD_WIDTH  lane k at bits [k*32 +: 32]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_mode  out  1  mode of the output beat
- out_tag  out  TAG_WIDTH  tag of the output beat
- out_data  out  LANES*WORD_WIDTH  transformed lanes
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While reset is asserted, all stage valid bits, data, tags and modes are 0. Outputs therefore reset to out_valid=0, out_data=0, out_tag=0, out_mode=0, occupancy=0. in_ready=1 once reset is released.
- Transform, per lane, where x is the lane word:
  - mode 0: y = x ^ rotl(x,2) ^ rotl(x,10) ^ rotl(x,18) ^ rotl(x,24)
  - mode 1: y = x ^ rotl(x,13) ^ rotl(x,23)
  - Computed combinationally from in_data and registered into stage 0. Mode and tag travel with the data.
- Elastic pipeline:
  - stage i advances when it is empty, or when stage i+1 can accept.
  - The last stage can accept when it is empty or out_ready=1.
  - Bubbles collapse: a valid beat moves into an empty stage even if later stages are stalled.
  - in_ready is combinational from downstream readiness; there is no combinational path from in_valid to in_ready.
- Handshakes: a transfer occurs when valid && ready on a rising clk edge.
  - Latency is exactly DEPTH cycles from input acceptance to out_valid when there is no backpressure.
  - Throughput is 1 beat/cycle.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_tag and out_mode are held stable.
- Capacity: the pipeline holds at most DEPTH beats.
  - When full and out_ready=0, in_ready=0.
  - When full and out_ready=1, a simultaneous input is accepted the same cycle.
- Flush:
  - Clears all valid bits on the next edge. Data registers need not be cleared.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - flush takes priority over all transfers.
- Occupancy: equals the count of valid stages, updated each edge.
- Reset mid-operation: all in-flight beats are discarded, and no out_valid is produced for them after release.
- Ordering: beats leave in acceptance order. Lanes never mix.

Decomposition:
- Shared package sm4_pkg holds:
  - SM4_WORD_WIDTH=32
  - L rotation constants 2/10/18/24
  - L' rotation constants 13/23
  - mode encoding MODE_L=1'b0, MODE_LKEY=1'b1
- Natural sub-module: l_transform_core, a purely combinational single-word transform with a mode input, instantiated LANES times via generate.
- The elastic stage chain stays in l_transform_pipe.

Test Plan:
- Reset then single beat with LANES=1, DEPTH=1, mode 0, in_data=0x00000001, tag=3 -> one cycle later out_valid=1, out_data=0x01040405, out_tag=3.
- Mode 1 with in_data=0x80000000 -> out_data=0x80401000. Mode 0 with 0x80000000 -> 0x80820202.
- LANES=2, DEPTH=3, back-to-back beats with alternating modes and out_ready=1 -> results appear 3 cycles after each input, one per cycle, in order, with correct per-lane values and modes.
- DEPTH=3 with out_ready=0 and 4 input attempts -> 3 accepted, occupancy=3, in_ready=0, out_data held stable. Then out_ready=1 -> 3 beats drain in order while a new input is accepted concurrently.
- DEPTH=3 with a beat stalled at the output and two stage bubbles, then a new input -> the new beat fills the next empty stage on each edge, and occupancy tracks correctly.
- flush asserted with 2 beats in flight -> occupancy=0 and out_valid=0 next cycle, and no flushed beat emerges. Async rst_n asserted mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/sm4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm4_pkg
// Description : Shared SM4 constants: word width, rotation amounts of the
//               round transform L and the key-expansion transform L', the
//               transform-mode encoding and a word rotate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sm4_pkg;

    localparam int SM4_WORD_WIDTH = 32;

    // Round linear transform L
    localparam int L_ROT_0 = 2;
    localparam int L_ROT_1 = 10;
    localparam int L_ROT_2 = 18;
    localparam int L_ROT_3 = 24;

    // Key-expansion linear transform L'
    localparam int LKEY_ROT_0 = 13;
    localparam int LKEY_ROT_1 = 23;

    typedef enum logic {
        MODE_L    = 1'b0,   // encrypt/decrypt round
        MODE_LKEY = 1'b1    // key schedule
    } sm4_mode_e;

    function automatic logic [SM4_WORD_WIDTH-1:0] rotl(
        input logic [SM4_WORD_WIDTH-1:0] x,
        input int                        n
    );
        return (x << n) | (x >> (SM4_WORD_WIDTH - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/l_transform_core.sv
`default_nettype none
// ============================================================================
// Module      : l_transform_core
// Description : Purely combinational single-word SM4 linear transform.
//               i_mode = MODE_L    : y = x ^ x<<<2 ^ x<<<10 ^ x<<<18 ^ x<<<24
//               i_mode = MODE_LKEY : y = x ^ x<<<13 ^ x<<<23
// Ports       : i_mode  - transform select
//               i_word  - input word
//               o_word  - transformed word
// Revision    : 1.0 - initial release
// ============================================================================
module l_transform_core
    import sm4_pkg::*;
(
    input  logic                      i_mode,
    input  logic [SM4_WORD_WIDTH-1:0] i_word,
    output logic [SM4_WORD_WIDTH-1:0] o_word
);

    logic [SM4_WORD_WIDTH-1:0] w_l;
    logic [SM4_WORD_WIDTH-1:0] w_lkey;

    assign w_l    = i_word ^ rotl(i_word, L_ROT_0) ^ rotl(i_word, L_ROT_1)
                           ^ rotl(i_word, L_ROT_2) ^ rotl(i_word, L_ROT_3);
    assign w_lkey = i_word ^ rotl(i_word, LKEY_ROT_0) ^ rotl(i_word, LKEY_ROT_1);

    assign o_word = (i_mode == MODE_LKEY) ? w_lkey : w_l;

endmodule
`default_nettype wire

// File: rtl/l_transform_pipe.sv
`default_nettype none
// ============================================================================
// Module      : l_transform_pipe
// Description : LANES-wide SM4 L / L' transform followed by an elastic
//               valid/ready chain of DEPTH register stages. Stage 0 captures
//               the transform result; later stages are elastic delay with
//               bubble collapse. Mode and tag travel with each beat.
// Ports       : clk, rst_n           - clock, async active-low reset
//               flush                - synchronous clear of all stage valids
//               in_valid/in_ready    - input handshake
//               in_mode/in_tag/in_data
//               out_valid/out_ready  - output handshake
//               out_mode/out_tag/out_data
//               occupancy            - number of valid stages
// Revision    : 1.0 - initial release
// ============================================================================
module l_transform_pipe
    import sm4_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int DEPTH      = 1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    input  logic [LANES*WORD_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_mode,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic [LANES*WORD_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int DW    = LANES * WORD_WIDTH;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // The rotation amounts only make sense for 32-bit words.
    if (WORD_WIDTH != SM4_WORD_WIDTH) begin : g_bad_word_width
        $error("l_transform_pipe: WORD_WIDTH must be %0d", SM4_WORD_WIDTH);
    end

    // ------------------------------------------------------------------
    // Per-lane transform
    // ------------------------------------------------------------------
    logic [DW-1:0] w_xform;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        l_transform_core u_core (
            .i_mode (in_mode),
            .i_word (in_data[k*WORD_WIDTH +: WORD_WIDTH]),
            .o_word (w_xform[k*WORD_WIDTH +: WORD_WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]     r_vld;
    logic                 r_mode [DEPTH];
    logic [TAG_WIDTH-1:0] r_tag  [DEPTH];
    logic [DW-1:0]        r_data [DEPTH];

    // Stage i can take a new beat when any stage from i to the end is
    // empty, or the output is being consumed. This is the unrolled form of
    // "empty or the next stage can accept", which avoids a ripple chain.
    logic [DEPTH-1:0] w_can_acc;
    logic             w_any_empty;

    always_comb begin
        w_any_empty = 1'b0;
        w_can_acc   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_any_empty  = w_any_empty | ~r_vld[i];
            w_can_acc[i] = out_ready | w_any_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mode[i] <= 1'b0;
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            // Payload only moves with a valid beat, so bubbles passing
            // through do not disturb the registered data.
            if (w_can_acc[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_mode[0] <= in_mode;
                    r_tag[0]  <= in_tag;
                    r_data[0] <= w_xform;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_can_acc[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_mode[i] <= r_mode[i-1];
                        r_tag[i]  <= r_tag[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_can_acc[0] & ~flush;
    assign out_valid = r_vld[DEPTH-1];
    assign out_mode  = r_mode[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign occupancy = OCC_W'($countones(r_vld));

endmodule
`default_nettype wire

// File: tb/tb_l_transform_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_l_transform_pipe
// Description : Self-checking bench for l_transform_pipe. One instance with
//               LANES=1/DEPTH=1 for the fixed transform vectors, one with
//               LANES=2/DEPTH=3 checked cycle by cycle against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l_transform_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- instance 1: LANES=1, DEPTH=1 ----------------
    logic        f1, iv1, ir1, im1, ov1, or1, om1;
    logic [3:0]  it1, ot1;
    logic [31:0] id1, od1;
    logic [0:0]  occ1;

    l_transform_pipe #(.WORD_WIDTH(32), .LANES(1), .DEPTH(1), .TAG_WIDTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_mode(im1), .in_tag(it1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_mode(om1), .out_tag(ot1), .out_data(od1),
        .occupancy(occ1)
    );

    // ---------------- instance 3: LANES=2, DEPTH=3 ----------------
    logic        f3, iv3, ir3, im3, ov3, or3, om3;
    logic [3:0]  it3, ot3;
    logic [63:0] id3, od3;
    logic [1:0]  occ3;

    l_transform_pipe #(.WORD_WIDTH(32), .LANES(2), .DEPTH(3), .TAG_WIDTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(f3),
        .in_valid(iv3), .in_ready(ir3), .in_mode(im3), .in_tag(it3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_mode(om3), .out_tag(ot3), .out_data(od3),
        .occupancy(occ3)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63-n -: 32];
    endfunction

    function automatic logic [31:0] ref_word(input logic m, input logic [31:0] x);
        if (m) return x ^ ref_rotl(x, 13) ^ ref_rotl(x, 23);
        return x ^ ref_rotl(x, 2) ^ ref_rotl(x, 10) ^ ref_rotl(x, 18) ^ ref_rotl(x, 24);
    endfunction

    function automatic logic [63:0] ref_beat(input logic m, input logic [63:0] x);
        return {ref_word(m, x[63:32]), ref_word(m, x[31:0])};
    endfunction

    typedef struct {
        logic        mode;
        logic [3:0]  tag;
        logic [63:0] data;
        int          acc;
    } beat_t;

    beat_t q[$];

    // Expected values (from the model) and DUT snapshot for the current cycle.
    logic        e_ir3, e_ov3;
    logic [1:0]  e_occ3;
    beat_t       e_head;
    logic        s_ir3, s_ov3, s_om3;
    logic [3:0]  s_ot3;
    logic [63:0] s_od3;
    logic [1:0]  s_occ3;

    // One cycle on instance 3: drive at negedge, snapshot DUT and model
    // expectations 1 time unit later, then advance the model at posedge.
    // A beat is at the output once it has aged 3 cycles and is oldest.
    task automatic drive3(input logic v, input logic m, input logic [3:0] t,
                          input logic [63:0] d, input logic r, input logic fl);
        int c0;
        @(negedge clk);
        iv3 = v; im3 = m; it3 = t; id3 = d; or3 = r; f3 = fl;
        #1;
        c0     = cyc;
        e_ir3  = !fl && (q.size() < 3 || r);
        e_occ3 = 2'(q.size());
        e_ov3  = (q.size() > 0) && (c0 - q[0].acc >= 3);
        if (q.size() > 0) e_head = q[0];
        s_ir3 = ir3; s_ov3 = ov3; s_om3 = om3; s_ot3 = ot3; s_od3 = od3; s_occ3 = occ3;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (e_ov3 && r) void'(q.pop_front());
            if (v && e_ir3) q.push_back('{mode: m, tag: t, data: ref_beat(m, d), acc: c0});
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        f1 = 0; iv1 = 0; im1 = 0; it1 = 0; id1 = 0; or1 = 1;
        f3 = 0; iv3 = 0; im3 = 0; it3 = 0; id3 = 0; or3 = 0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({ov1, om1, ot1, od1, occ1} !== '0) $display("FAIL reset dut1 outputs: got %h required 0", {ov1, om1, ot1, od1, occ1}); else n_pass++;
        n_chk++; if ({ov3, om3, ot3, od3, occ3} !== '0) $display("FAIL reset dut3 outputs: got %h required 0", {ov3, om3, ot3, od3, occ3}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (ir1 !== 1'b1) $display("FAIL reset dut1 in_ready: got %b required 1", ir1); else n_pass++;
        n_chk++; if (ir3 !== 1'b1) $display("FAIL reset dut3 in_ready: got %b required 1", ir3); else n_pass++;
        q.delete();
    endtask

    task automatic test_single();
        logic [31:0] xin [3];
        logic [31:0] xexp[3];
        logic        xm  [3];
        logic [3:0]  xt  [3];
        xin  = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        xexp = '{32'h0104_0405, 32'h8040_1000, 32'h8082_0202};
        xm   = '{1'b0, 1'b1, 1'b0};
        xt   = '{4'd3, 4'd5, 4'd9};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv1 = 1; im1 = xm[i]; it1 = xt[i]; id1 = xin[i]; or1 = 1;
            #1;
            n_chk++; if (ir1 !== 1'b1) $display("FAIL single[%0d] in_ready: got %b required 1", i, ir1); else n_pass++;
            @(negedge clk);
            iv1 = 0;
            #1;
            n_chk++; if (ov1 !== 1'b1) $display("FAIL single[%0d] out_valid: got %b required 1", i, ov1); else n_pass++;
            n_chk++; if (od1 !== xexp[i]) $display("FAIL single[%0d] out_data: got %h required %h", i, od1, xexp[i]); else n_pass++;
            n_chk++; if ({om1, ot1} !== {xm[i], xt[i]}) $display("FAIL single[%0d] mode/tag: got %b/%h required %b/%h", i, om1, ot1, xm[i], xt[i]); else n_pass++;
            n_chk++; if (occ1 !== 1'b1) $display("FAIL single[%0d] occupancy: got %0d required 1", i, occ1); else n_pass++;
            @(negedge clk);
            #1;
            n_chk++; if (ov1 !== 1'b0) $display("FAIL single[%0d] drained out_valid: got %b required 0", i, ov1); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 13; i++) begin
            drive3(i < 8, i[0], 4'(i), rnd64(), 1'b1, 1'b0);
            n_chk++; if (s_ir3 !== e_ir3) $display("FAIL b2b[%0d] in_ready: got %b required %b", i, s_ir3, e_ir3); else n_pass++;
            n_chk++; if (s_ov3 !== e_ov3) $display("FAIL b2b[%0d] out_valid: got %b required %b", i, s_ov3, e_ov3); else n_pass++;
            if (e_ov3 && s_ov3) begin
                n_chk++; if (s_od3 !== e_head.data) $display("FAIL b2b[%0d] out_data: got %h required %h", i, s_od3, e_head.data); else n_pass++;
                n_chk++; if ({s_om3, s_ot3} !== {e_head.mode, e_head.tag}) $display("FAIL b2b[%0d] mode/tag: got %b/%h required %b/%h", i, s_om3, s_ot3, e_head.mode, e_head.tag); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            drive3(1'b1, $urandom_range(0, 1) == 1, 4'(i + 1), rnd64(), 1'b0, 1'b0);
            n_chk++; if (s_ir3 !== e_ir3) $display("FAIL bp attempt[%0d] in_ready: got %b required %b", i, s_ir3, e_ir3); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            drive3(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
            n_chk++; if (s_occ3 !== e_occ3) $display("FAIL bp stall[%0d] occupancy: got %0d required %0d", i, s_occ3, e_occ3); else n_pass++;
            n_chk++; if (s_ir3 !== e_ir3) $display("FAIL bp stall[%0d] in_ready: got %b required %b", i, s_ir3, e_ir3); else n_pass++;
            n_chk++; if ({s_ov3, s_od3, s_ot3} !== {e_ov3, e_head.data, e_head.tag}) $display("FAIL bp stall[%0d] held beat: got %b/%h/%h required %b/%h/%h", i, s_ov3, s_od3, s_ot3, e_ov3, e_head.data, e_head.tag); else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            drive3(i == 0, 1'b1, 4'hA, rnd64(), 1'b1, 1'b0);
            n_chk++; if (s_ir3 !== e_ir3) $display("FAIL bp drain[%0d] in_ready: got %b required %b", i, s_ir3, e_ir3); else n_pass++;
            n_chk++; if (s_ov3 !== e_ov3) $display("FAIL bp drain[%0d] out_valid: got %b required %b", i, s_ov3, e_ov3); else n_pass++;
            if (e_ov3 && s_ov3) begin
                n_chk++; if ({s_od3, s_ot3} !== {e_head.data, e_head.tag}) $display("FAIL bp drain[%0d] beat: got %h/%h required %h/%h", i, s_od3, s_ot3, e_head.data, e_head.tag); else n_pass++;
            end
        end
    endtask

    task automatic test_bubbles();
        // A enters, ages into the last stage while out_ready=0, then B
        // enters behind two empty stages.
        for (int i = 0; i < 10; i++) begin
            drive3(i == 0 || i == 3, 1'b0, 4'(i), rnd64(), i >= 7, 1'b0);
            n_chk++; if (s_occ3 !== e_occ3) $display("FAIL bubble[%0d] occupancy: got %0d required %0d", i, s_occ3, e_occ3); else n_pass++;
            n_chk++; if ({s_ov3, s_ir3} !== {e_ov3, e_ir3}) $display("FAIL bubble[%0d] valid/ready: got %b%b required %b%b", i, s_ov3, s_ir3, e_ov3, e_ir3); else n_pass++;
            if (e_ov3 && s_ov3) begin
                n_chk++; if (s_od3 !== e_head.data) $display("FAIL bubble[%0d] out_data: got %h required %h", i, s_od3, e_head.data); else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            drive3(i < 3, 1'b1, 4'(i), rnd64(), i >= 3, i == 2);
            n_chk++; if (s_ir3 !== e_ir3) $display("FAIL flush[%0d] in_ready: got %b required %b", i, s_ir3, e_ir3); else n_pass++;
            n_chk++; if ({s_ov3, s_occ3} !== {e_ov3, e_occ3}) $display("FAIL flush[%0d] valid/occupancy: got %b/%0d required %b/%0d", i, s_ov3, s_occ3, e_ov3, e_occ3); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive3(($urandom % 4) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
                   rnd64(), ($urandom % 3) != 0, ($urandom % 24) == 0);
            n_chk++; if ({s_ir3, s_ov3, s_occ3} !== {e_ir3, e_ov3, e_occ3}) $display("FAIL random[%0d] ready/valid/occ: got %b/%b/%0d required %b/%b/%0d", i, s_ir3, s_ov3, s_occ3, e_ir3, e_ov3, e_occ3); else n_pass++;
            if (e_ov3 && s_ov3) begin
                n_chk++; if ({s_om3, s_ot3, s_od3} !== {e_head.mode, e_head.tag, e_head.data}) $display("FAIL random[%0d] beat: got %b/%h/%h required %b/%h/%h", i, s_om3, s_ot3, s_od3, e_head.mode, e_head.tag, e_head.data); else n_pass++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive3(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0);
            n_chk++; if ({s_ov3, s_occ3} !== {e_ov3, e_occ3}) $display("FAIL random drain[%0d] valid/occ: got %b/%0d required %b/%0d", i, s_ov3, s_occ3, e_ov3, e_occ3); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive3(1'b1, 1'b0, 4'(i + 1), rnd64(), 1'b0, 1'b0);
        @(negedge clk);
        iv3 = 1'b0; or3 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({ov3, om3, ot3, od3, occ3} !== '0) $display("FAIL async reset dut3 outputs: got %h required 0", {ov3, om3, ot3, od3, occ3}); else n_pass++;
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive3(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0);
            n_chk++; if ({s_ov3, s_occ3} !== {e_ov3, e_occ3}) $display("FAIL post reset[%0d] valid/occ: got %b/%0d required %b/%0d", i, s_ov3, s_occ3, e_ov3, e_occ3); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
